// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: IF/IE/IME state, fixed-priority arbitration,
// HALT wake request and the 5-M-cycle interrupt dispatch sequencer.
module sm83_irq_ctrl #(
  parameter int unsigned NUM_IRQ    = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_m,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               if_wr_en,
  input  logic               ie_wr_en,
  input  logic [7:0]         wr_data,
  output logic [7:0]         if_rd_data,
  output logic [7:0]         ie_rd_data,
  input  logic               ei_exec,
  input  logic               di_exec,
  input  logic               reti_exec,
  input  logic               instr_boundary,
  output logic               wake,
  output logic               irq_take,
  output logic               busy,
  output logic               push_hi,
  output logic               push_lo,
  output logic               vec_valid,
  output logic [15:0]        vec_addr
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {
    D_IDLE,
    D_W0,
    D_W1,
    D_PH,
    D_PL,
    D_JP
  } dstate_t;

  dstate_t              state_q, state_d;
  logic [NUM_IRQ-1:0]   src_q;
  logic [NUM_IRQ-1:0]   if_q, if_d;
  logic [7:0]           ie_q;
  logic                 ime_q;
  logic                 ime_pend_q;
  logic [NUM_IRQ-1:0]   pending;
  logic [IDX_W-1:0]     sel_idx, sel_idx_q;
  logic                 sel_hit, sel_hit_q;
  logic [15:0]          vec_q;

  assign pending    = if_q & ie_q[NUM_IRQ-1:0];
  assign wake       = |pending;
  assign busy       = (state_q != D_IDLE);
  assign vec_addr   = vec_q;
  assign if_rd_data = {{(8 - NUM_IRQ){1'b1}}, if_q};
  assign ie_rd_data = ie_q;

  // Scan from the top down so the lowest set index is the one left standing.
  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (pending[i-1]) begin
        sel_idx = IDX_W'(i - 1);
        sel_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    irq_take  = 1'b0;
    push_hi   = 1'b0;
    push_lo   = 1'b0;
    vec_valid = 1'b0;
    case (state_q)
      D_IDLE: if (tick_m && instr_boundary && ime_q && (|pending)) begin
        irq_take = 1'b1;
        state_d  = D_W0;
      end
      D_W0: if (tick_m) state_d = D_W1;
      D_W1: if (tick_m) state_d = D_PH;
      D_PH: begin
        push_hi = tick_m;
        if (tick_m) state_d = D_PL;
      end
      D_PL: begin
        push_lo = tick_m;
        if (tick_m) state_d = D_JP;
      end
      D_JP: begin
        vec_valid = tick_m;
        if (tick_m) state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

  // Dispatch clear first, then CPU write, then source edges so an edge always wins.
  always_comb begin
    if_d = if_q;
    if (vec_valid && sel_hit_q) if_d[sel_idx_q] = 1'b0;
    if (if_wr_en) if_d = wr_data[NUM_IRQ-1:0];
    if_d = if_d | (irq_src & ~src_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= D_IDLE;
      src_q      <= '0;
      if_q       <= '0;
      ie_q       <= '0;
      ime_q      <= 1'b0;
      ime_pend_q <= 1'b0;
      sel_idx_q  <= '0;
      sel_hit_q  <= 1'b0;
      vec_q      <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= irq_src;
      if_q    <= if_d;
      if (ie_wr_en) ie_q <= wr_data;
      if (state_q == D_PH && tick_m) begin
        sel_idx_q <= sel_idx;
        sel_hit_q <= sel_hit;
        vec_q     <= sel_hit ? VEC_BASE + 16'(32'(sel_idx) * VEC_STRIDE) : '0;
      end
      // Later assignments take precedence: DI beats everything, take beats RETI.
      if (tick_m) begin
        if (instr_boundary && ime_pend_q) begin
          ime_q      <= 1'b1;
          ime_pend_q <= 1'b0;
        end
        if (ei_exec)   ime_pend_q <= 1'b1;
        if (reti_exec) ime_q <= 1'b1;
        if (irq_take)  ime_q <= 1'b0;
        if (di_exec) begin
          ime_q      <= 1'b0;
          ime_pend_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Directed bench for sm83_irq_ctrl: dispatch timing, vectors, EI delay,
// DI override, cancelled dispatch, IF/IE readback and mid-dispatch reset.
module tb_sm83_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_m = 1'b0;
  logic [4:0]  irq_src = '0;
  logic        if_wr_en = 1'b0;
  logic        ie_wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  if_rd_data;
  logic [7:0]  ie_rd_data;
  logic        ei_exec = 1'b0;
  logic        di_exec = 1'b0;
  logic        reti_exec = 1'b0;
  logic        instr_boundary = 1'b0;
  logic        wake;
  logic        irq_take;
  logic        busy;
  logic        push_hi;
  logic        push_lo;
  logic        vec_valid;
  logic [15:0] vec_addr;

  int errors = 0;
  int checks = 0;

  logic        o_take, o_ph, o_pl, o_vv;
  logic [15:0] o_va;

  sm83_irq_ctrl #(.NUM_IRQ(5), .VEC_BASE(16'h0040), .VEC_STRIDE(8)) dut (
    .clk(clk), .rst(rst), .tick_m(tick_m), .irq_src(irq_src),
    .if_wr_en(if_wr_en), .ie_wr_en(ie_wr_en), .wr_data(wr_data),
    .if_rd_data(if_rd_data), .ie_rd_data(ie_rd_data),
    .ei_exec(ei_exec), .di_exec(di_exec), .reti_exec(reti_exec),
    .instr_boundary(instr_boundary), .wake(wake), .irq_take(irq_take),
    .busy(busy), .push_hi(push_hi), .push_lo(push_lo),
    .vec_valid(vec_valid), .vec_addr(vec_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One M-cycle: tick_m high for one clk, strobes captured before the edge.
  task automatic tick(input logic b, input logic ei, input logic di, input logic reti);
    @(negedge clk);
    tick_m = 1'b1; instr_boundary = b; ei_exec = ei; di_exec = di; reti_exec = reti;
    #1;
    o_take = irq_take; o_ph = push_hi; o_pl = push_lo; o_vv = vec_valid; o_va = vec_addr;
    @(negedge clk);
    tick_m = 1'b0; instr_boundary = 1'b0; ei_exec = 1'b0; di_exec = 1'b0; reti_exec = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wr_if(input logic [7:0] d);
    @(negedge clk); if_wr_en = 1'b1; wr_data = d;
    @(negedge clk); if_wr_en = 1'b0;
  endtask

  task automatic wr_ie(input logic [7:0] d);
    @(negedge clk); ie_wr_en = 1'b1; wr_data = d;
    @(negedge clk); ie_wr_en = 1'b0;
  endtask

  task automatic pulse_src(input logic [4:0] s);
    @(negedge clk); irq_src = s;
    @(negedge clk); irq_src = '0;
  endtask

  // Five dispatch M-cycles after the take; expected strobes per tick.
  task automatic run_dispatch(input string tag, input logic [15:0] exp_va);
    logic [4:0] ph, pl, vv;
    ph = '0; pl = '0; vv = '0;
    for (int k = 0; k < 5; k++) begin
      chk({tag, "_busy"}, 16'(busy), 16'h1);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      ph[k] = o_ph; pl[k] = o_pl; vv[k] = o_vv;
      if (k == 4) chk({tag, "_vec_addr"}, o_va, exp_va);
    end
    chk({tag, "_push_hi_seq"}, 16'(ph), 16'h04);
    chk({tag, "_push_lo_seq"}, 16'(pl), 16'h08);
    chk({tag, "_vec_valid_seq"}, 16'(vv), 16'h10);
    chk({tag, "_busy_after"}, 16'(busy), 16'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_if", 16'(if_rd_data), 16'h00E0);
    chk("rst_ie", 16'(ie_rd_data), 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_wake", 16'(wake), 16'h0);
    chk("rst_vec", vec_addr, 16'h0000);

    // Test 1: EI delay, source edge, vector 0x50
    wr_ie(8'h1F);
    chk("ie_rd_1f", 16'(ie_rd_data), 16'h001F);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_ei_take", 16'(o_take), 16'h0);
    pulse_src(5'b00100);
    chk("t1_wake", 16'(wake), 16'h1);
    chk("t1_if", 16'(if_rd_data), 16'h00E4);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_delay_take", 16'(o_take), 16'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_take", 16'(o_take), 16'h1);
    run_dispatch("t1", 16'h0050);
    chk("t1_if_after", 16'(if_rd_data), 16'h00E0);
    wr_if(8'h04);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_ime_cleared", 16'(o_take), 16'h0);

    // Test 2: priority among IF=1F & IE=06 -> source 1
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t2_reti_take", 16'(o_take), 16'h0);
    wr_ie(8'h06);
    wr_if(8'h1F);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_take", 16'(o_take), 16'h1);
    run_dispatch("t2", 16'h0048);
    chk("t2_if_after", 16'(if_rd_data), 16'h00FD);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_ime_cleared", 16'(o_take), 16'h0);

    // Test 3: EI then DI on the next instruction
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_ei_take", 16'(o_take), 16'h0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3_di_take", 16'(o_take), 16'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_after_take_a", 16'(o_take), 16'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_after_take_b", 16'(o_take), 16'h0);
    chk("t3_busy", 16'(busy), 16'h0);

    // Test 4: IE cleared during D_PH -> cancelled dispatch
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_take", 16'(o_take), 16'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    wr_ie(8'h00);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_push_hi", 16'(o_ph), 16'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_push_lo", 16'(o_pl), 16'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_vec_valid", 16'(o_vv), 16'h1);
    chk("t4_vec_addr", o_va, 16'h0000);
    chk("t4_if_after", 16'(if_rd_data), 16'h00FD);
    chk("t4_ie_after", 16'(ie_rd_data), 16'h0000);

    // Test 5: IME=0, wake without dispatch
    wr_ie(8'h01);
    wr_if(8'h01);
    chk("t5_wake", 16'(wake), 16'h1);
    chk("t5_if_rd", 16'(if_rd_data), 16'h00E1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_take", 16'(o_take), 16'h0);

    // Same-clk IF write and source edge: edge wins
    @(negedge clk); if_wr_en = 1'b1; wr_data = 8'h00; irq_src = 5'b00010;
    @(negedge clk); if_wr_en = 1'b0; irq_src = '0;
    chk("edge_wins", 16'(if_rd_data), 16'h00E2);
    wr_if(8'h01);

    // Test 6: reset during D_PL
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_take", 16'(o_take), 16'h1);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_in_dispatch", 16'(busy), 16'h1);
    chk("t6_vec_latched", vec_addr, 16'h0040);
    @(negedge clk); rst = 1'b1; tick_m = 1'b1;
    #1;
    chk("t6_rst_busy", 16'(busy), 16'h0);
    chk("t6_rst_push_lo", 16'(push_lo), 16'h0);
    chk("t6_rst_vec", vec_addr, 16'h0000);
    chk("t6_rst_if", 16'(if_rd_data), 16'h00E0);
    chk("t6_rst_ie", 16'(ie_rd_data), 16'h0000);
    chk("t6_rst_wake", 16'(wake), 16'h0);
    @(negedge clk); tick_m = 1'b0;
    @(negedge clk); rst = 1'b0;
    wr_ie(8'h01);
    wr_if(8'h01);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_ime_reset", 16'(o_take), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
